// File: rtl/booth_radix4_sequencer.sv
// Sequential radix-4 Booth multiplier: recodes the multiplier, feeds one partial product per cycle
// to an external 16-bit adder, and accumulates the returned sum into a signed 16-bit product.
module booth_radix4_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   add_a,
    output logic [2*WIDTH-1:0]   add_b,
    output logic                 add_cin,
    input  logic [2*WIDTH-1:0]   add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int STEPS = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int CW    = $clog2(STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_m;
    logic [WIDTH:0]  r_q;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_add_a;
    logic [PW-1:0]   r_add_b;
    logic            r_add_cin;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_out_valid;
    logic [PW-1:0]   r_product;

    logic [PW-1:0]   w_m_in;
    logic [WIDTH:0]  w_q_in;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW:0]     w_pp_first;
    logic [PW:0]     w_pp_next;
    logic            w_unused_cout;

    // Booth digit selection; returns {carry_in, adder operand b}, negation done as ~mag + 1.
    function automatic logic [PW:0] booth_pp(input logic [2:0] trip,
                                             input logic [PW-1:0] m,
                                             input logic [CW-1:0] idx);
        logic [PW-1:0] mag;
        logic          neg;
        case (trip)
            3'b001, 3'b010: begin mag = m;                neg = 1'b0; end
            3'b011:         begin mag = m << 1;           neg = 1'b0; end
            3'b100:         begin mag = m << 1;           neg = 1'b1; end
            3'b101, 3'b110: begin mag = m;                neg = 1'b1; end
            default:        begin mag = {PW{1'b0}};       neg = 1'b0; end
        endcase
        mag = mag << {idx, 1'b0};
        return neg ? {1'b1, ~mag} : {1'b0, mag};
    endfunction

    assign w_unused_cout = add_cout;

    // Partial products for the digit about to be presented (first on accept, next during RUN).
    always_comb begin
        w_m_in     = {{WIDTH{mcand[WIDTH-1]}}, mcand};
        w_q_in     = {mplier, 1'b0};
        w_cnt_nxt  = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        w_pp_first = booth_pp(w_q_in[2:0], w_m_in, {CW{1'b0}});
        w_pp_next  = booth_pp(r_q[{w_cnt_nxt, 1'b0} +: 3], r_m, w_cnt_nxt);
    end

    // Control FSM with registered datapath and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_m         <= {PW{1'b0}};
            r_q         <= {(WIDTH+1){1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_acc       <= {PW{1'b0}};
            r_add_a     <= {PW{1'b0}};
            r_add_b     <= {PW{1'b0}};
            r_add_cin   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= {PW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_m        <= w_m_in;
                        r_q        <= w_q_in;
                        r_acc      <= {PW{1'b0}};
                        r_cnt      <= {CW{1'b0}};
                        r_add_a    <= {PW{1'b0}};
                        r_add_b    <= w_pp_first[PW-1:0];
                        r_add_cin  <= w_pp_first[PW];
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= add_sum;
                    r_cnt <= w_cnt_nxt;
                    if (r_cnt == CW'(STEPS - 1)) begin
                        r_product   <= add_sum;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_add_a     <= {PW{1'b0}};
                        r_add_b     <= {PW{1'b0}};
                        r_add_cin   <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_add_a   <= add_sum;
                        r_add_b   <= w_pp_next[PW-1:0];
                        r_add_cin <= w_pp_next[PW];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_add_a     <= {PW{1'b0}};
                    r_add_b     <= {PW{1'b0}};
                    r_add_cin   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;

endmodule

// File: tb/tb_booth_radix4_sequencer.sv
// Self-checking bench: directed vector table, reset/back-pressure sequences, and random pairs
// checked against plain signed arithmetic and per-step Booth digit expectations.
module tb_booth_radix4_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the 16-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    booth_radix4_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mcand(mcand), .mplier(mplier), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          stall;
        bit          hold_valid;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Booth digit i of multiplier b, from the signed-digit definition.
    function automatic int booth_digit(input logic [7:0] b, input int i);
        logic [8:0] q;
        int lo, mid, hi;
        q   = {b, 1'b0};
        lo  = int'(q[2*i]);
        mid = int'(q[2*i+1]);
        hi  = int'(q[2*i+2]);
        return lo + mid - 2 * hi;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input int stall, input bit hold_valid);
        int cyc;
        int m;
        int d;
        int mag;
        int acc;
        logic [15:0] eb;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        mcand     = a;
        mplier    = b;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = hold_valid;
        mcand    = 8'($urandom);
        mplier   = 8'($urandom);
        m   = int'($signed(a));
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            d   = booth_digit(b, i);
            mag = (d < 0 ? -d : d) * m * (1 << (2 * i));
            eb  = (d < 0) ? ~16'(mag) : 16'(mag);
            chk("add_a", {16'd0, add_a}, {16'd0, 16'(acc)});
            chk("add_b", {16'd0, add_b}, {16'd0, eb});
            chk("add_cin", {31'd0, add_cin}, {31'd0, (d < 0)});
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("in_ready_run", {31'd0, in_ready}, 32'd0);
            chk("out_valid_early", {31'd0, out_valid}, 32'd0);
            acc = acc + d * m * (1 << (2 * i));
            @(negedge clk);
        end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("product", {16'd0, product}, {16'd0, exp});
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("add_b_done", {15'd0, add_b, add_cin}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("held_valid", {31'd0, out_valid}, 32'd1);
            chk("held_product", {16'd0, product}, {16'd0, exp});
            chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("drained_valid", {31'd0, out_valid}, 32'd0);
        chk("drained_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t tbl[7];
        logic [7:0] ra;
        logic [7:0] rb;
        tbl[0] = '{8'h03, 8'h05, 16'h000F, 0, 1'b0};
        tbl[1] = '{8'h80, 8'h80, 16'h4000, 1, 1'b0};
        tbl[2] = '{8'h80, 8'h7F, 16'hC080, 0, 1'b0};
        tbl[3] = '{8'h07, 8'hFF, 16'hFFF9, 2, 1'b0};
        tbl[4] = '{8'h00, 8'hB3, 16'h0000, 0, 1'b0};
        tbl[5] = '{8'h13, 8'h6C, 16'h0804, 0, 1'b0};
        tbl[6] = '{8'h21, 8'hF3, 16'hFE53, 10, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mcand     = 8'd0;
        mplier    = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
        chk("rst_adder", {15'd0, add_a | add_b, add_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++)
            run_op(tbl[v].a, tbl[v].b, tbl[v].exp, tbl[v].stall, tbl[v].hold_valid);

        // Reset pulsed in the middle of a multiplication.
        in_valid = 1'b1;
        mcand    = 8'h55;
        mplier   = 8'h33;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_run_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_product", {16'd0, product}, 32'd0);
        chk("mid_rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
        chk("mid_rst_adder", {15'd0, add_a | add_b, add_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h09, 8'h09, 16'h0051, 0, 1'b0);

        for (int k = 0; k < 2000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 16'(int'($signed(ra)) * int'($signed(rb))),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
